// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - EX/MEM/WB scoreboard driving forwarding, load-use stall and branch flush; PIPE_HAZARD_PERF_CNT_EN adds stall/flush counters
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int ZERO_REG   = 31,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rn,
  input  logic [REG_ADDR_W-1:0] id_rm,
  input  logic                  id_uses_rn,
  input  logic                  id_uses_rm,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  br_taken,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  flush_ifid,
  output logic                  flush_idex,
  output logic                  flush_exmem,
  output logic [1:0]            fwd_a,
`ifdef PIPE_HAZARD_PERF_CNT_EN
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
`else
  output logic [1:0]            fwd_b
`endif
);

  localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(ZERO_REG);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
    logic [REG_ADDR_W-1:0] rn;
    logic [REG_ADDR_W-1:0] rm;
    logic                  uses_rn;
    logic                  uses_rm;
  } slot_t;

  slot_t ex_q, mem_q, wb_q, id_slot;
  logic  load_use;
  logic  stall;

  // A slot can only supply a hazard if it really writes a non-zero register
  function automatic logic is_src(input slot_t s);
    return s.valid & s.regwrite & (s.rd != ZERO_IDX);
  endfunction

  // MEM is the younger producer, so it wins over WB
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src, input logic use_src,
                                         input slot_t ex, input slot_t mem, input slot_t wb);
    if (!(ex.valid & use_src))          return 2'b00;
    if (is_src(mem) && mem.rd == src)   return 2'b10;
    if (is_src(wb) && wb.rd == src)     return 2'b01;
    return 2'b00;
  endfunction

  assign id_slot = '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, memread: id_memread,
                     rn: id_rn, rm: id_rm, uses_rn: id_uses_rn, uses_rm: id_uses_rm};

  assign load_use = is_src(ex_q) & ex_q.memread &
                    ((id_uses_rn & (ex_q.rd == id_rn)) | (id_uses_rm & (ex_q.rd == id_rm)));

  // Control outputs; reset forces the idle values and a taken branch masks any stall
  always_comb begin
    stall       = 1'b0;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    if (!rst) begin
      fwd_a = fwd_sel(ex_q.rn, ex_q.uses_rn, ex_q, mem_q, wb_q);
      fwd_b = fwd_sel(ex_q.rm, ex_q.uses_rm, ex_q, mem_q, wb_q);
      if (br_taken) begin
        flush_ifid  = 1'b1;
        flush_idex  = 1'b1;
        flush_exmem = 1'b1;
      end else if (load_use) begin
        stall      = 1'b1;
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        flush_idex = 1'b1;
      end
    end
  end

  // Scoreboard shift: bubble into EX on stall, squash EX and MEM on a taken branch
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (br_taken) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= mem_q;
    end else begin
      ex_q  <= stall ? '0 : id_slot;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

`ifdef PIPE_HAZARD_PERF_CNT_EN
  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != {CNT_W{1'b1}})    stall_cnt <= stall_cnt + 1'b1;
      if (br_taken && flush_cnt != {CNT_W{1'b1}}) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

  // Fields kept for scoreboard completeness that no decision reads downstream
  logic unused_slot_bits;
  assign unused_slot_bits = ^{mem_q.memread, mem_q.rn, mem_q.rm, mem_q.uses_rn, mem_q.uses_rm,
                              wb_q.memread, wb_q.rn, wb_q.rm, wb_q.uses_rn, wb_q.uses_rm};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed and random bench for pipeline_hazard_ctrl against an in-flight instruction model
module tb_pipeline_hazard_ctrl;

  localparam int RW = 5;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] id_rn, id_rm, id_rd;
  logic          id_uses_rn, id_uses_rm, id_regwrite, id_memread, br_taken;
  logic          pc_en, ifid_en, flush_ifid, flush_idex, flush_exmem;
  logic [1:0]    fwd_a, fwd_b;
`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [CW-1:0] stall_cnt, flush_cnt;
`endif

  pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .ZERO_REG(31), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .br_taken(br_taken),
    .pc_en(pc_en), .ifid_en(ifid_en), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .flush_exmem(flush_exmem), .fwd_a(fwd_a),
`ifdef PIPE_HAZARD_PERF_CNT_EN
    .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`else
    .fwd_b(fwd_b)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: the instructions in flight, index = age after ID (0 -> EX, 1 -> MEM, 2 -> WB)
  typedef struct {
    bit valid;
    int rd;
    bit wr;
    bit ld;
    int rn;
    int rm;
    bit urn;
    bit urm;
  } instr_t;

  instr_t inflight[3];
  instr_t bubble;
  longint m_stall = 0;
  longint m_flush = 0;
  int     pool[4] = '{1, 2, 3, 31};

  function automatic bit writes(input instr_t i, input int r);
    return i.valid && i.wr && i.rd != 31 && i.rd == r;
  endfunction

  // The newest older writer of r supplies the operand
  function automatic int exp_fwd(input int r, input bit u);
    if (!inflight[0].valid || !u) return 0;
    for (int a = 1; a < 3; a++)
      if (writes(inflight[a], r)) return (a == 1) ? 2 : 1;
    return 0;
  endfunction

  task automatic drive(input int rd, input bit wr, input bit ld, input int rn, input int rm,
                       input bit urn, input bit urm, input bit br);
    id_rd = RW'(rd); id_regwrite = wr; id_memread = ld;
    id_rn = RW'(rn); id_rm = RW'(rm); id_uses_rn = urn; id_uses_rm = urm;
    br_taken = br;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Check this cycle's outputs, then advance the model over the clock edge
  task automatic cycle();
    bit     st, br;
    instr_t id;
    #1;
    br = !rst && br_taken;
    st = !rst && !br_taken && inflight[0].ld &&
         ((id_uses_rn && writes(inflight[0], int'(id_rn))) ||
          (id_uses_rm && writes(inflight[0], int'(id_rm))));
    check("pc_en", pc_en, !st);
    check("ifid_en", ifid_en, !st);
    check("flush_ifid", flush_ifid, br);
    check("flush_idex", flush_idex, br || st);
    check("flush_exmem", flush_exmem, br);
    check("fwd_a", fwd_a, rst ? 0 : exp_fwd(inflight[0].rn, inflight[0].urn));
    check("fwd_b", fwd_b, rst ? 0 : exp_fwd(inflight[0].rm, inflight[0].urm));
`ifdef PIPE_HAZARD_PERF_CNT_EN
    if (!rst) begin
      check("stall_cnt", stall_cnt, 32'(m_stall));
      check("flush_cnt", flush_cnt, 32'(m_flush));
    end
`endif
    id = '{valid: 1'b1, rd: int'(id_rd), wr: id_regwrite, ld: id_memread,
           rn: int'(id_rn), rm: int'(id_rm), urn: id_uses_rn, urm: id_uses_rm};
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 3; k++) inflight[k] = bubble;
      m_stall = 0;
      m_flush = 0;
    end else if (br) begin
      inflight[2] = inflight[1];
      inflight[1] = bubble;
      inflight[0] = bubble;
      m_flush++;
    end else begin
      inflight[2] = inflight[1];
      inflight[1] = inflight[0];
      inflight[0] = st ? bubble : id;
      if (st) m_stall++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nop();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    nop();
    cycle();
    check("rst_pc_en", pc_en, 1);

    // 1: ADDS X1,X2,X3 ; SUB X4,X1,X5
    do_reset();
    drive(1, 1, 0, 2, 3, 1, 1, 0); cycle();
    drive(4, 1, 0, 1, 5, 1, 1, 0); cycle();
    nop();
    check("t1_fwd_a", fwd_a, 2);
    check("t1_fwd_b", fwd_b, 0);
    cycle();

    // 2: ADD X1 ; NOP ; ORR X6,X7,X1
    do_reset();
    drive(1, 1, 0, 2, 3, 1, 1, 0); cycle();
    nop(); cycle();
    drive(6, 1, 0, 7, 1, 1, 1, 0); cycle();
    nop();
    check("t2_fwd_a", fwd_a, 0);
    check("t2_fwd_b", fwd_b, 1);
    cycle();

    // 3: ADD X1 ; ADD X1 ; use X1
    do_reset();
    drive(1, 1, 0, 2, 3, 1, 1, 0); cycle();
    drive(1, 1, 0, 4, 5, 1, 1, 0); cycle();
    drive(8, 1, 0, 1, 1, 1, 1, 0); cycle();
    nop();
    check("t3_fwd_a", fwd_a, 2);
    cycle();

    // 4: LDUR X9,[X0] ; ADD X10,X9,X9
    do_reset();
    drive(9, 1, 1, 0, 0, 1, 0, 0); cycle();
    drive(10, 1, 0, 9, 9, 1, 1, 0);
    #1;
    check("t4_stall_pc_en", pc_en, 0);
    check("t4_stall_flush_idex", flush_idex, 1);
    cycle();
    cycle();
    nop();
    check("t4_fwd_a", fwd_a, 1);
    check("t4_fwd_b", fwd_b, 1);
`ifdef PIPE_HAZARD_PERF_CNT_EN
    check("t4_stall_cnt", stall_cnt, 1);
`endif
    cycle();

    // 5: taken branch while a load-use stall is pending
    do_reset();
    drive(9, 1, 1, 0, 0, 1, 0, 0); cycle();
    drive(10, 1, 0, 9, 9, 1, 1, 1);
    #1;
    check("t5_pc_en", pc_en, 1);
    check("t5_flush_exmem", flush_exmem, 1);
    cycle();
    nop(); cycle();
`ifdef PIPE_HAZARD_PERF_CNT_EN
    check("t5_flush_cnt", flush_cnt, 1);
    check("t5_stall_cnt", stall_cnt, 0);
`endif

    // 6: X31 never hazards; reset mid-stall
    do_reset();
    drive(31, 1, 0, 2, 3, 1, 1, 0); cycle();
    drive(31, 1, 1, 31, 31, 1, 1, 0); cycle();
    drive(5, 1, 0, 31, 31, 1, 1, 0); cycle();
    nop(); cycle();
    drive(9, 1, 1, 0, 0, 1, 0, 0); cycle();
    drive(10, 1, 0, 9, 9, 1, 1, 0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    check("t6_pc_en", pc_en, 1);
    check("t6_flush_idex", flush_idex, 0);
`ifdef PIPE_HAZARD_PERF_CNT_EN
    check("t6_stall_cnt", stall_cnt, 0);
`endif
    cycle();

    // Random traffic over a small register pool to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      drive(pool[$urandom_range(0, 3)], 1'($urandom), 1'($urandom_range(0, 2) == 0),
            pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)],
            1'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
